// File: rtl/bram_burst_arbiter.sv
// bram_burst_arbiter: N-channel burst arbiter in front of one BRAM port, with fixed-latency read-return routing.
// Define ARB_RR_EN for round-robin channel selection; otherwise the lowest requesting channel index wins.
module bram_burst_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 3,
    parameter int RD_LAT  = 10,
    localparam int CW     = $clog2(NUM_CH)
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [NUM_CH-1:0]           ch_req_i,
    input  logic [NUM_CH-1:0]           ch_we_i,
    input  logic [NUM_CH*ADDR_W-1:0]    ch_addr_i,
    input  logic [NUM_CH*BURST_W-1:0]   ch_len_i,
    input  logic [NUM_CH*DATA_W-1:0]    ch_wdata_i,
    output logic [NUM_CH-1:0]           ch_ack_o,
    output logic [NUM_CH-1:0]           ch_rvalid_o,
    output logic [DATA_W-1:0]           ch_rdata_o,
    output logic                        bram_in_valid_o,
    output logic                        bram_wr_o,
    output logic [ADDR_W-1:0]           bram_addr_o,
    output logic [DATA_W-1:0]           bram_data_in_o,
    input  logic [DATA_W-1:0]           bram_rdata_i,
    output logic [CW-1:0]               grant_o,
    output logic                        busy_o
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t               state_q, state_d;
    logic [CW-1:0]        w_q, w_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [BURST_W-1:0]   len_q, len_d;
    logic [BURST_W-1:0]   beat_q, beat_d;
    logic                 we_q, we_d;
    logic                 pv_q [RD_LAT];
    logic                 pv_d [RD_LAT];
    logic [CW-1:0]        pid_q [RD_LAT];
    logic [CW-1:0]        pid_d [RD_LAT];
    logic [CW-1:0]        win;
    logic                 cmd;
    logic                 rd_cmd;
`ifdef ARB_RR_EN
    logic [CW-1:0]        ptr_q, ptr_d;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            w_q     <= '0;
            base_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            we_q    <= 1'b0;
`ifdef ARB_RR_EN
            ptr_q   <= '0;
`endif
            for (int i = 0; i < RD_LAT; i++) begin
                pv_q[i]  <= 1'b0;
                pid_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            base_q  <= base_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            we_q    <= we_d;
`ifdef ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
            pv_q    <= pv_d;
            pid_q   <= pid_d;
        end
    end

    // Descending scan so the candidate closest to the start point is the last one assigned.
    always_comb begin
        win = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
`ifdef ARB_RR_EN
            if (ch_req_i[(int'(ptr_q) + i) % NUM_CH]) win = CW'((int'(ptr_q) + i) % NUM_CH);
`else
            if (ch_req_i[i]) win = CW'(i);
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        base_d  = base_q;
        len_d   = len_q;
        beat_d  = beat_q;
        we_d    = we_q;
`ifdef ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        if (state_q == IDLE) begin
            if (|ch_req_i) begin
                state_d = BURST;
                w_d     = win;
                base_d  = ch_addr_i[win*ADDR_W +: ADDR_W];
                len_d   = ch_len_i[win*BURST_W +: BURST_W];
                we_d    = ch_we_i[win];
                beat_d  = '0;
            end
        end else if (!ch_req_i[w_q] || beat_q == len_q) begin
            state_d = IDLE;
`ifdef ARB_RR_EN
            ptr_d   = (w_q == CW'(NUM_CH - 1)) ? '0 : w_q + 1'b1;
`endif
        end else begin
            beat_d = beat_q + 1'b1;
        end
        pv_d[0]  = rd_cmd;
        pid_d[0] = w_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i]  = pv_q[i-1];
            pid_d[i] = pid_q[i-1];
        end
    end

    // A dropped request in BURST suppresses the beat entirely.
    always_comb begin
        cmd             = (state_q == BURST) && ch_req_i[w_q];
        rd_cmd          = cmd && !we_q;
        busy_o          = state_q == BURST;
        grant_o         = w_q;
        bram_in_valid_o = cmd;
        bram_wr_o       = cmd && we_q;
        bram_addr_o     = cmd ? base_q + ADDR_W'(beat_q) : '0;
        bram_data_in_o  = (cmd && we_q) ? ch_wdata_i[w_q*DATA_W +: DATA_W] : '0;
        ch_ack_o        = cmd ? NUM_CH'(1) << w_q : '0;
        ch_rvalid_o     = pv_q[RD_LAT-1] ? NUM_CH'(1) << pid_q[RD_LAT-1] : '0;
        ch_rdata_o      = bram_rdata_i;
    end
endmodule

// File: tb/tb_bram_burst_arbiter.sv
// tb_bram_burst_arbiter: directed bench with a transaction-level reference model, BRAM stub and requester drivers.
`timescale 1ns/1ps
module tb_bram_burst_arbiter;
    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 32;
    localparam int BURST_W = 3;
    localparam int RD_LAT  = 10;
    localparam int CW      = $clog2(NUM_CH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NUM_CH-1:0] req, we;
    logic [ADDR_W-1:0] addr [NUM_CH];
    logic [BURST_W-1:0] len [NUM_CH];
    logic [DATA_W-1:0] wdata [NUM_CH];
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*BURST_W-1:0] ch_len;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0] ack, rvalid;
    logic [DATA_W-1:0] rdata, bdin, bram_rdata;
    logic bv, bwr, busy;
    logic [ADDR_W-1:0] baddr;
    logic [CW-1:0] grant;

    always #5 clk = ~clk;

    always_comb begin
        ch_addr = '0;
        ch_len = '0;
        ch_wdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_addr[c*ADDR_W +: ADDR_W] = addr[c];
            ch_len[c*BURST_W +: BURST_W] = len[c];
            ch_wdata[c*DATA_W +: DATA_W] = wdata[c];
        end
    end

    bram_burst_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .RD_LAT(RD_LAT)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .ch_req_i(req), .ch_we_i(we), .ch_addr_i(ch_addr),
        .ch_len_i(ch_len), .ch_wdata_i(ch_wdata), .ch_ack_o(ack), .ch_rvalid_o(rvalid),
        .ch_rdata_o(rdata), .bram_in_valid_o(bv), .bram_wr_o(bwr), .bram_addr_o(baddr),
        .bram_data_in_o(bdin), .bram_rdata_i(bram_rdata), .grant_o(grant), .busy_o(busy)
    );

    typedef struct { int cyc; int ch; logic wr; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } cmd_t;
    typedef struct { int cyc; int ch; logic [DATA_W-1:0] d; } rv_t;
    cmd_t cmd_q [$];
    rv_t rv_q [$];

    int checks = 0, errors = 0, cyc = 0;
    logic [DATA_W-1:0] mem [1<<ADDR_W];
    logic [DATA_W-1:0] sched [int];
    int rv_ch [int];
    logic [DATA_W-1:0] rv_dat [int];
    logic [NUM_CH-1:0] ack_seen = '0;
    bit armed = 0;

    // reference model state: what the arbiter must be doing, in burst terms
    bit m_busy = 0, m_we = 0;
    int m_ch = 0, m_ptr = 0, m_beat = 0, m_len = 0;
    logic [ADDR_W-1:0] m_base = '0;

    // requester job state
    int bursts [NUM_CH], abort_at [NUM_CH], beat [NUM_CH], tot [NUM_CH];
    logic [DATA_W-1:0] wbase [NUM_CH];

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    function automatic int oh_idx(input logic [NUM_CH-1:0] v);
        for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int pick();
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef ARB_RR_EN
            int c = (m_ptr + k) % NUM_CH;
`else
            int c = k;
`endif
            if (req[c]) return c;
        end
        return 0;
    endfunction

    always @(negedge clk) begin : cmp
        logic e_v, e_wr;
        logic [ADDR_W-1:0] e_a;
        logic [DATA_W-1:0] e_d;
        logic [NUM_CH-1:0] e_ack, e_rv;
        e_v = m_busy && req[m_ch];
        e_wr = e_v && m_we;
        e_a = e_v ? ADDR_W'(m_base + m_beat) : '0;
        e_d = e_wr ? wdata[m_ch] : '0;
        e_ack = e_v ? NUM_CH'(1) << m_ch : '0;
        e_rv = rv_ch.exists(cyc) ? NUM_CH'(1) << rv_ch[cyc] : '0;
        if (armed) begin
            chk("bram_in_valid", bv, e_v);
            chk("bram_wr", bwr, e_wr);
            chk("bram_addr", baddr, e_a);
            chk("bram_data_in", bdin, e_d);
            chk("ch_ack", ack, e_ack);
            chk("ch_rvalid", rvalid, e_rv);
            chk("busy", busy, m_busy);
            chk("grant", grant, m_ch);
            if (e_rv != 0) chk("ch_rdata", rdata, rv_dat[cyc]);
        end
        if (rst) begin
            m_busy = 0; m_ch = 0; m_ptr = 0; m_beat = 0;
            rv_ch.delete(); rv_dat.delete();
            armed = 1;
        end else if (!m_busy) begin
            if (|req) begin
                m_ch = pick(); m_busy = 1; m_beat = 0;
                m_base = addr[m_ch]; m_len = int'(len[m_ch]); m_we = we[m_ch];
            end
        end else if (!req[m_ch]) begin
            m_busy = 0; m_ptr = (m_ch + 1) % NUM_CH;
        end else begin
            if (!m_we) begin rv_ch[cyc+RD_LAT] = m_ch; rv_dat[cyc+RD_LAT] = mem[e_a]; end
            if (m_beat == m_len) begin m_busy = 0; m_ptr = (m_ch + 1) % NUM_CH; end
            else m_beat++;
        end
        ack_seen = ack;
        if (bv === 1'b1) begin
            cmd_q.push_back('{cyc, oh_idx(ack), bwr, baddr, bdin});
            if (bwr) mem[baddr] = bdin;
            else sched[cyc+RD_LAT] = mem[baddr];
        end
        if (|rvalid) rv_q.push_back('{cyc, oh_idx(rvalid), rdata});
    end

    task automatic step();
        @(posedge clk); #1;
        cyc++;
        bram_rdata = sched.exists(cyc) ? sched[cyc] : '0;
        for (int c = 0; c < NUM_CH; c++) if (ack_seen[c] && req[c]) begin
            beat[c]++; tot[c]++;
            if (abort_at[c] != 0 && tot[c] == abort_at[c]) begin req[c] = 0; bursts[c] = 0; end
            else if (beat[c] == int'(len[c]) + 1) begin
                beat[c] = 0; bursts[c]--;
                if (bursts[c] == 0) req[c] = 0;
            end
            wdata[c] = wbase[c] + DATA_W'(beat[c]);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic start_job(input int c, input logic w, input logic [ADDR_W-1:0] a, input int l, input int nb, input int ab, input logic [DATA_W-1:0] wb);
        we[c] = w; addr[c] = a; len[c] = BURST_W'(l); bursts[c] = nb; abort_at[c] = ab;
        beat[c] = 0; tot[c] = 0; wbase[c] = wb; wdata[c] = wb; req[c] = 1;
    endtask

    task automatic kill_all();
        for (int c = 0; c < NUM_CH; c++) begin
            req[c] = 0; we[c] = 0; addr[c] = '0; len[c] = '0; wdata[c] = '0;
            bursts[c] = 0; abort_at[c] = 0; beat[c] = 0; tot[c] = 0; wbase[c] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1; kill_all();
        run(3);
        rst = 0;
        cmd_q.delete(); rv_q.delete();
    endtask

    logic [ADDR_W-1:0] t2_a [4] = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
`ifdef ARB_RR_EN
    int t3_g [6] = '{0, 2, 3, 0, 2, 3};
`else
    int t3_g [6] = '{0, 0, 0, 0, 0, 0};
`endif

    initial begin
        int n, found;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hD000_0000 | i;
        bram_rdata = '0;
        kill_all();
        do_reset();
        #2;
        chk("reset busy", busy, 0);
        chk("reset grant", grant, 0);
        chk("reset valid", bv, 0);
        chk("reset ack", ack, 0);
        chk("reset rvalid", rvalid, 0);

        // single read burst on ch1
        start_job(1, 0, 13'h010, 3, 1, 0, 0);
        run(20);
        chk("t1 cmds", cmd_q.size(), 4);
        for (int i = 0; i < 4 && i < cmd_q.size(); i++) begin
            chk($sformatf("t1 addr%0d", i), cmd_q[i].a, 13'h010 + i);
            chk($sformatf("t1 ch%0d", i), cmd_q[i].ch, 1);
        end
        chk("t1 rv count", rv_q.size(), 4);
        if (rv_q.size() > 0 && cmd_q.size() > 0) begin
            chk("t1 latency", rv_q[0].cyc - cmd_q[0].cyc, 10);
            chk("t1 rv ch", rv_q[0].ch, 1);
            chk("t1 rdata", rv_q[0].d, 32'hD000_0010);
        end
        do_reset();

        // wrapping write burst on ch0
        start_job(0, 1, 13'h1FFE, 3, 1, 0, 32'hA0);
        run(20);
        chk("t2 cmds", cmd_q.size(), 4);
        for (int i = 0; i < 4 && i < cmd_q.size(); i++) begin
            chk($sformatf("t2 addr%0d", i), cmd_q[i].a, t2_a[i]);
            chk($sformatf("t2 data%0d", i), cmd_q[i].d, 32'hA0 + i);
            chk($sformatf("t2 wr%0d", i), cmd_q[i].wr, 1);
        end
        chk("t2 rv count", rv_q.size(), 0);
        do_reset();

        // contention between ch0, ch2, ch3
        start_job(0, 0, 13'h020, 0, 100, 0, 0);
        start_job(2, 0, 13'h022, 0, 100, 0, 0);
        start_job(3, 0, 13'h023, 0, 100, 0, 0);
        run(16);
        chk("t3 enough grants", cmd_q.size() >= 6, 1);
        for (int i = 0; i < 6 && i < cmd_q.size(); i++) chk($sformatf("t3 grant%0d", i), cmd_q[i].ch, t3_g[i]);
        do_reset();

        // abort of ch2 after 3 beats, ch3 waiting
        start_job(2, 0, 13'h100, 7, 1, 3, 0);
        start_job(3, 0, 13'h200, 0, 1, 0, 0);
        run(30);
        n = 0;
        foreach (cmd_q[i]) if (cmd_q[i].ch == 2) n++;
        chk("t4 ch2 cmds", n, 3);
        chk("t4 total cmds", cmd_q.size(), 4);
        chk("t4 next grant", cmd_q.size() > 3 ? cmd_q[3].ch : -1, 3);
        n = 0;
        foreach (rv_q[i]) if (rv_q[i].ch == 2) n++;
        chk("t4 ch2 rvalids", n, 3);
        do_reset();

        // reset two cycles into a read burst
        start_job(1, 0, 13'h300, 7, 1, 0, 0);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            step();
            found = cmd_q.size() > 0;
        end
        chk("t5 burst started", found, 1);
        step();
        rst = 1;
        step();
        rst = 0;
        kill_all();
        #2;
        chk("t5 valid", bv, 0);
        chk("t5 wr", bwr, 0);
        chk("t5 addr", baddr, 0);
        chk("t5 ack", ack, 0);
        chk("t5 busy", busy, 0);
        chk("t5 grant", grant, 0);
        chk("t5 rvalid", rvalid, 0);
        run(20);
        chk("t5 cmds", cmd_q.size(), 3);
        chk("t5 rv count", rv_q.size(), 0);
        do_reset();

        // ch1 write overlapping ch0 read returns
        start_job(0, 0, 13'h040, 1, 1, 0, 0);
        start_job(1, 1, 13'h050, 2, 1, 0, 32'h55);
        run(25);
        chk("t6 cmds", cmd_q.size(), 5);
        chk("t6 rv count", rv_q.size(), 2);
        if (cmd_q.size() == 5 && rv_q.size() == 2) begin
            chk("t6 wr ch", cmd_q[2].ch, 1);
            chk("t6 wr last", cmd_q[4].wr, 1);
            chk("t6 overlap", cmd_q[4].cyc < rv_q[0].cyc, 1);
            chk("t6 rv0 cyc", rv_q[0].cyc - cmd_q[0].cyc, 10);
            chk("t6 rv1 cyc", rv_q[1].cyc - cmd_q[1].cyc, 10);
            chk("t6 rv0 data", rv_q[0].d, 32'hD000_0040);
            chk("t6 rv1 data", rv_q[1].d, 32'hD000_0041);
            chk("t6 rv ch", rv_q[1].ch, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_burst_arbiter.md
Name: bram_burst_arbiter

Overview:
- Parametrised N-channel arbiter in front of a single BRAM controller port; successor to the fixed two-client CPU/DMA arbiter.
- Grants whole bursts of 1..2^BURST_W beats, read or write, to one channel at a time.
- Tracks in-flight reads through a fixed-latency return pipe and routes read-valid back to the issuing channel.
- Sits between CPU-WB/DMA/cache-fill requesters and one BRAM controller instance; one instance per BRAM bank.

Parameters:
- NUM_CH, 4, number of requester channels (2..8)
- ADDR_W, 13, BRAM word-address width
- DATA_W, 32, data width
- BURST_W, 3, burst-length field width; length field = beats-1
- RD_LAT, 10, cycles from BRAM read command to read data valid (>=1)

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, synchronous, active-high
- ch_req_i  in  NUM_CH  per-channel request; held high for the whole burst
- ch_we_i  in  NUM_CH  1=write, 0=read
- ch_addr_i  in  NUM_CH*ADDR_W  burst base word address, channel c at [c*ADDR_W +: ADDR_W]
- ch_len_i  in  NUM_CH*BURST_W  beats-1
- ch_wdata_i  in  NUM_CH*DATA_W  write data for the current beat
- ch_ack_o  out  NUM_CH  beat accepted (one pulse per beat)
- ch_rvalid_o  out  NUM_CH  read data valid for the channel
- ch_rdata_o  out  DATA_W  shared read data, qualified by ch_rvalid_o
- bram_in_valid_o  out  1  BRAM command valid
- bram_wr_o  out  1  0:R 1:W
- bram_addr_o  out  ADDR_W  BRAM word address
- bram_data_in_o  out  DATA_W  BRAM write data
- bram_rdata_i  in  DATA_W  BRAM read data, valid RD_LAT cycles after the read command
- grant_o  out  $clog2(NUM_CH)  current or last granted channel
- busy_o  out  1  burst in progress

Behaviour:
- Reset: all outputs 0; state IDLE; RR pointer 0; return pipe cleared. Reset mid-burst aborts the burst; in-flight reads are dropped and no rvalid is issued.
- State IDLE:
  - If any ch_req_i is high, select winner w = first requester at or after the RR pointer (wrapping).
  - Latch w, addr, len and we; set beat=0; busy_o=1; move to BURST.
  - No BRAM command is issued in IDLE, so there is one idle cycle between bursts.
- State BURST, each cycle:
  - Drive bram_in_valid_o=1, bram_addr_o=(base+beat) mod 2^ADDR_W (wraps silently), bram_wr_o=latched we.
  - bram_data_in_o = live ch_wdata_i slice of w; 0 for reads.
  - ch_ack_o[w]=1 in the same cycle; the requester presents the next beat's data the cycle after an ack.
- Exit BURST:
  - beat==len: after this beat go IDLE; RR pointer=(w+1) mod NUM_CH; busy_o=0 next cycle.
  - ch_req_i[w] low in a BURST cycle: no command and no ack that cycle; abort and go IDLE; pointer advances as above.
- Requests changing during a burst are ignored except ch_req_i[w]. Latched addr, len and we are not resampled.
- Read return:
  - Shift register of depth RD_LAT carries {valid, channel id} per read beat.
  - ch_rvalid_o[id]=1 exactly RD_LAT cycles after the command; ch_rdata_o=bram_rdata_i (passthrough).
  - Writes push valid=0 into the pipe. Read returns overlap freely with new bursts.
- Only one ch_ack_o bit and at most one ch_rvalid_o bit are high per cycle.

Optional Feature:
- ARB_RR_EN defined: round-robin selection as above.
- ARB_RR_EN undefined: fixed priority, lowest channel index wins; pointer logic removed; grant_o still reports the winner.

Test Plan:
- Single read: ch1 req, addr=0x010, len=3 -> bram_in_valid_o high 4 cycles, addr 0x010..0x013, ch_ack_o[1] 4 pulses, ch_rvalid_o[1] 4 pulses starting 10 cycles after the first command.
- Write burst: ch0 we=1, addr=0x1FFE, len=3, data 0xA0..0xA3 -> BRAM writes 0xA0@0x1FFE, 0xA1@0x1FFF, 0xA2@0x0000, 0xA3@0x0001 (wrap); no rvalid.
- Contention: ch0, ch2 and ch3 request continuously, each len=0 -> grants 0,2,3,0,2,3 with RR; with ARB_RR_EN off -> ch0 only.
- Abort: ch2 read len=7, ch_req_i[2] drops after 3 acks -> exactly 3 commands, 3 rvalids, IDLE, next grant goes to ch3 if requesting.
- Reset mid-operation: assert wb_rst_i 2 cycles after a read burst starts -> all outputs 0 next cycle, no rvalid ever appears for that burst.
- Overlap: ch0 read len=1 immediately followed by ch1 write -> ch1 write commands issue while ch0 rvalids are still pending; ch0 rvalids arrive at the correct cycles with correct data.
